spike_event_encoder: RTL
========================

Name: spike_event_encoder

Overview:
- Consumer end of the neuron core's membrane-potential output. Samples the core's 21-bit signed `final` potential once per neuron update step and compares it against a firing threshold.
- On a crossing it emits a spike pulse and queues a timestamped spike event behind a valid/ready handshake.
- It also drives the core's `set` input to re-initialise v to c, both after reset and after each spike, so it owns step-phase alignment.

Parameters:
- W, 21, membrane-potential width (signed two's complement, same fixed-point format as the core).
- STEP_CYCLES, 7, clock cycles per neuron update step.
- SAMPLE_PHASE, 1, phase (0..STEP_CYCLES-1) at which `v_final` is sampled. Phase 0 is the first cycle after `neuron_set` deasserts.
- V_TH, 21'sh18C00, firing threshold; spike when sampled v >= V_TH (signed compare).
- REFRACT_STEPS, 2, whole steps after a spike during which samples are ignored.
- TS_W, 16, timestamp width (step counter).
- DEPTH, 4, event FIFO depth (power of two).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  1 = run; 0 = hold in IDLE with `neuron_set` asserted
- v_final  in  W  sampled membrane potential from neuron core
- neuron_set  out  1  drives core `set`; 1 = (re)initialise v to c
- spike  out  1  one-cycle pulse on a detected crossing
- ev_valid  out  1  event FIFO non-empty
- ev_ready  in  1  consumer accepts head event
- ev_ts  out  TS_W  timestamp (step count) of head event
- ev_v  out  W  sampled potential of head event
- spike_cnt  out  16  saturating total spikes detected
- ovf  out  1  sticky: an event was dropped on full FIFO
- clr_ovf  in  1  clears `ovf`

Behaviour:
- Reset values: `neuron_set` = 1, `spike` = 0, `ev_valid` = 0, `ev_ts` = 0, `ev_v` = 0, `spike_cnt` = 0, `ovf` = 0. Internally, phase = 0, step counter = 0, FIFO pointers = 0, state = IDLE.
- FSM states: IDLE, INIT, RUN, REFRACT.
  - IDLE: `neuron_set` = 1. Go to INIT when `enable` = 1.
  - INIT: `neuron_set` = 1 for exactly one cycle, then RUN with phase = 0.
  - RUN: `neuron_set` = 0. Phase counts 0..STEP_CYCLES-1 and wraps; the step counter increments on each wrap (modulo 2^TS_W).
    - At phase == SAMPLE_PHASE, compare `v_final` >= V_TH.
    - On a hit, `spike` = 1 in the following cycle, the event {step counter, v_final} is pushed, and the state goes to INIT (core re-init).
    - Since the current step is abandoned on a hit, the step counter increments on that exit.
    - The refractory counter is loaded with REFRACT_STEPS; INIT then goes to REFRACT instead of RUN when that counter is non-zero.
  - REFRACT: behaves like RUN but does not compare. The refractory counter decrements on each step wrap; at zero, go to RUN.
- `enable` = 0 in any state: go to IDLE next cycle. Phase and refractory counter clear; the step counter and FIFO contents are kept.
- Exactly one sample per step. No double detection is possible within a step.
- FIFO:
  - Registered outputs; no fall-through. A push into an empty FIFO gives `ev_valid` = 1 on the next cycle.
  - Pop occurs when `ev_valid` && `ev_ready`.
  - Push when full: accepted only if a pop occurs the same cycle; otherwise the event is dropped, `ovf` is set, and `spike` still pulses and `spike_cnt` still increments.
  - Simultaneous push and pop when empty cannot happen, because there is no fall-through.
- `spike_cnt` saturates at 16'hFFFF.
- `clr_ovf` together with a same-cycle drop: `ovf` stays 1 (set wins).
- `rst` mid-operation: all state returns to reset values immediately (asynchronous); the FIFO is flushed.
- The signed compare uses the full W bits. The threshold is inclusive: v == V_TH spikes.

Decomposition:
- Shared package `neuron_pkg`:
  - constants W = 21 and V_TH default;
  - FSM state enum {IDLE, INIT, RUN, REFRACT};
  - event struct {ts, v}.
- Sub-module `event_fifo`: parameterised by DEPTH and the data width. Synchronous, async reset, valid/ready pop, full/empty flags, registered head.
- FSM, phase counter, step counter and comparator live in the top.

Test Plan:
- Reset then `enable` = 1, with `v_final` held at -65 (raw 21'h1FBF00 region, below threshold):
  - `neuron_set` is high for the IDLE cycles plus 1 INIT cycle, then low;
  - no spike over 20 steps;
  - the step counter reads 20 (check via a forced spike).
- With `v_final` = V_TH at step 3 sample phase:
  - `spike` pulses once;
  - the event reads ev_ts = 3, ev_v = 21'sh18C00;
  - `neuron_set` pulses one cycle;
  - no sample is taken for the next 2 steps.
- With `v_final` = V_TH-1 permanently: no spike. With V_TH+1 permanently: spikes every 1+REFRACT_STEPS steps, with timestamps 0,3,6,9.
- With `ev_ready` = 0 and 5 spikes: 4 events are queued, `ovf` = 1 after the 5th, and `spike_cnt` = 5. Then pulse `clr_ovf` and drain with `ev_ready` = 1: timestamps come out in order and `ev_valid` falls after the 4th pop.
- FIFO full plus `ev_ready` = 1 on the spike cycle: no drop, `ovf` stays 0, and the new event appears last.
- Assert `rst` while in REFRACT with 2 events queued: all outputs are at reset values in the same cycle and `ev_valid` = 0. The first spike after re-enable gets ts = 0.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared constants and types for the neuron core and its spike event encoder.
package neuron_pkg;

    localparam int W    = 21;
    localparam int TS_W = 16;
    localparam logic signed [W-1:0] V_TH = 21'sh18C00;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_INIT    = 2'd1;
    localparam state_t ST_RUN     = 2'd2;
    localparam state_t ST_REFRACT = 2'd3;

    typedef struct packed {
        logic        [TS_W-1:0] ts;
        logic signed [W-1:0]    v;
    } spike_event_t;

endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO with valid/ready pop and a head that is read straight from storage flops.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 37
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop_ready,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          pop;
    logic          accept;

    assign empty  = (wr_q == rd_q);
    assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop    = !empty && pop_ready;
    // A push into a full FIFO only lands if the head leaves in the same cycle.
    assign accept = push && (!full || pop);
    assign head   = mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (accept) begin
            mem_d[wr_q[AW-1:0]] = push_data;
            wr_d = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/spike_event_encoder.sv
// Samples the neuron core's membrane potential once per step, detects threshold crossings,
// re-initialises the core after each spike and queues timestamped spike events.
module spike_event_encoder #(
    parameter int                       W             = neuron_pkg::W,
    parameter int                       STEP_CYCLES   = 7,
    parameter int                       SAMPLE_PHASE  = 1,
    parameter logic signed [W-1:0]      V_TH          = neuron_pkg::V_TH,
    parameter int                       REFRACT_STEPS = 2,
    parameter int                       TS_W          = neuron_pkg::TS_W,
    parameter int                       DEPTH         = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic signed [W-1:0]    v_final,
    output logic                   neuron_set,
    output logic                   spike,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic        [TS_W-1:0] ev_ts,
    output logic signed [W-1:0]    ev_v,
    output logic        [15:0]     spike_cnt,
    output logic                   ovf,
    input  logic                   clr_ovf
);

    import neuron_pkg::*;

    localparam int PH_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int RF_W = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(STEP_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_PHASE);
    localparam logic [RF_W-1:0] RF_LOAD   = RF_W'(REFRACT_STEPS);

    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [TS_W-1:0] step_q, step_d;
    logic [RF_W-1:0] refr_q, refr_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            spike_q, spike_d;
    logic            ovf_q, ovf_d;

    logic            wrap;
    logic            hit;
    logic            drop;
    logic            fifo_full;
    logic            fifo_empty;
    spike_event_t    push_ev;
    spike_event_t    head_ev;

    assign wrap = (phase_q == PH_LAST);

    // Step sequencing: one compare per step, and a hit abandons the rest of the step.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        step_d  = step_q;
        refr_d  = refr_q;
        hit     = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            phase_d = '0;
            refr_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_INIT;
                end
                ST_INIT: begin
                    phase_d = '0;
                    state_d = (refr_q != '0) ? ST_REFRACT : ST_RUN;
                end
                ST_RUN: begin
                    phase_d = wrap ? '0 : phase_q + 1'b1;
                    if ((phase_q == PH_SAMPLE) && (v_final >= V_TH)) begin
                        hit     = 1'b1;
                        state_d = ST_INIT;
                        phase_d = '0;
                        refr_d  = RF_LOAD;
                        step_d  = step_q + 1'b1;
                    end else if (wrap) begin
                        step_d = step_q + 1'b1;
                    end
                end
                default: begin
                    phase_d = wrap ? '0 : phase_q + 1'b1;
                    if (wrap) begin
                        step_d = step_q + 1'b1;
                        refr_d = (refr_q != '0) ? refr_q - 1'b1 : '0;
                        if (refr_q <= RF_W'(1)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
            endcase
        end
    end

    assign drop = hit && fifo_full && !(ev_valid && ev_ready);

    always_comb begin
        spike_d = hit;
        cnt_d   = (hit && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
        ovf_d   = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            step_q  <= '0;
            refr_q  <= '0;
            cnt_q   <= '0;
            spike_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            refr_q  <= refr_d;
            cnt_q   <= cnt_d;
            spike_q <= spike_d;
            ovf_q   <= ovf_d;
        end
    end

    assign push_ev.ts = step_q;
    assign push_ev.v  = v_final;

    event_fifo #(
        .DEPTH (DEPTH),
        .DW    ($bits(spike_event_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (hit),
        .push_data (push_ev),
        .pop_ready (ev_ready),
        .head      (head_ev),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign neuron_set = (state_q == ST_IDLE) || (state_q == ST_INIT);
    assign spike      = spike_q;
    assign ev_valid   = !fifo_empty;
    assign ev_ts      = head_ev.ts;
    assign ev_v       = head_ev.v;
    assign spike_cnt  = cnt_q;
    assign ovf        = ovf_q;

endmodule
